// File: rtl/bucket_request_pkg.sv
// Shared probe-engine definitions used by the bucket request stage.
package bucket_request_pkg;

  localparam int ADDR_W  = 48;
  localparam int VALUE_W = 64;

  typedef enum logic {
    REQ_EMPTY = 1'b0,
    REQ_HELD  = 1'b1
  } req_state_t;

  // Bucket byte address; hash bits shifted past the address width are dropped
  // and the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] bucket_addr(
    input logic [ADDR_W-1:0]  base,
    input logic [VALUE_W-1:0] hash,
    input int                 shift
  );
    logic [VALUE_W-1:0] shifted;
    shifted = hash << shift;
    return base + shifted[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/bucket_request_pending_fifo.sv
// In-order first-word-fall-through FIFO that parks probe values until their
// bucket comes back. The head reads as zero while the FIFO is empty.
module pending_fifo
  import bucket_request_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int WIDTH      = VALUE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = count_q[DEPTH_LOG2];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; a pop on empty leaves everything untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bucket_request.sv
// Turns (value, hash) pairs from the hash stage into tagged bucket read
// requests and queues each value in order for the compare stage.
//
// state     | meaning
// ----------|------------------------------------------------------------
// REQ_EMPTY | no request presented on the memory port
// REQ_HELD  | request valid; held stable until memory takes it (no stall)
module bucket_request
  import bucket_request_pkg::*;
#(
  parameter int BUCKET_SHIFT    = 6,
  parameter int PEND_DEPTH_LOG2 = 5,
  parameter int TAG_W           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          table_base_in,
  input  logic                       empty_in,
  output logic                       read_en_out,
  input  logic [VALUE_W-1:0]         value_in,
  input  logic [VALUE_W-1:0]         hash_in,
  output logic                       mem_req_valid_out,
  output logic [ADDR_W-1:0]          mem_req_addr_out,
  output logic [TAG_W-1:0]           mem_req_tag_out,
  input  logic                       mem_req_stall_in,
  output logic                       empty_out,
  input  logic                       read_en_in,
  output logic [VALUE_W-1:0]         value_out,
  output logic [PEND_DEPTH_LOG2:0]   outstanding_out,
  output logic                       done
);

  req_state_t          state_q;
  req_state_t          state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    tag_cnt_q;
  logic                accept;
  logic                space;
  logic                load;
  logic                pend_full;

  // Space comes from the registered count, so a same-cycle downstream pop
  // does not open a slot until the next cycle.
  assign accept = (state_q == REQ_HELD) & ~mem_req_stall_in;
  assign space  = ~pend_full;
  assign load   = ~rst & ~empty_in & space & ((state_q == REQ_EMPTY) | accept);

  assign read_en_out       = load;
  assign mem_req_valid_out = (state_q == REQ_HELD);
  assign mem_req_addr_out  = addr_q;
  assign mem_req_tag_out   = tag_q;
  assign done              = empty_in & (state_q == REQ_EMPTY) & empty_out;

  // Request register next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_EMPTY: if (load) state_d = REQ_HELD;
      REQ_HELD:  if (accept && !load) state_d = REQ_EMPTY;
      default:   state_d = REQ_EMPTY;
    endcase
  end

  // Request state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= REQ_EMPTY;
    else     state_q <= state_d;
  end

  // Request address/tag capture and sequential tag generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      tag_q     <= '0;
      tag_cnt_q <= '0;
    end else if (load) begin
      addr_q    <= bucket_addr(table_base_in, hash_in, BUCKET_SHIFT);
      tag_q     <= tag_cnt_q;
      tag_cnt_q <= tag_cnt_q + 1'b1;
    end
  end

  pending_fifo #(
    .DEPTH_LOG2 (PEND_DEPTH_LOG2),
    .WIDTH      (VALUE_W)
  ) u_pending (
    .clk       (clk),
    .rst       (rst),
    .push      (load),
    .push_data (value_in),
    .pop       (read_en_in),
    .pop_data  (value_out),
    .count     (outstanding_out),
    .empty     (empty_out),
    .full      (pend_full)
  );

endmodule
